// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between a pipeline producer/consumer pair and pipe_stage_reg.
// The master side drives entries, flush and out_ready; the slave side is the register itself.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 107,
    parameter int STAGES = 1
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] ctrl_out;
    logic [DATA_W-1:0] data_out;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output flush, in_valid, ctrl_in, data_in, out_ready,
        input  in_ready, out_valid, ctrl_out, data_out, occupancy
    );

    modport slave (
        input  flush, in_valid, ctrl_in, data_in, out_ready,
        output in_ready, out_valid, ctrl_out, data_out, occupancy
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic multi-slot pipeline register with valid/ready handshake, bubble collapsing
// and a synchronous flush that zeroes every control bit so squashed entries cannot write.
module pipe_stage_slot #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 107
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic              i_adv,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_v,
    output logic [CTRL_W-1:0] o_c,
    output logic [DATA_W-1:0] o_d
);
    logic              r_v;
    logic [CTRL_W-1:0] r_c;
    logic [DATA_W-1:0] r_d;

    // Data is left untouched on flush/drain; only v and ctrl must be clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= 1'b0;
            r_c <= '0;
            r_d <= '0;
        end else if (i_flush) begin
            r_v <= 1'b0;
            r_c <= '0;
        end else if (i_load) begin
            r_v <= 1'b1;
            r_c <= i_ctrl;
            r_d <= i_data;
        end else if (i_adv) begin
            r_v <= 1'b0;
            r_c <= '0;
        end
    end

    assign o_v = r_v;
    assign o_c = r_c;
    assign o_d = r_d;
endmodule

module pipe_stage_reg #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 107,
    parameter int STAGES = 1
) (
    input logic clk,
    input logic rst,
    pipe_stage_reg_if.slave bus
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0]             w_v;
    logic [STAGES-1:0][CTRL_W-1:0] w_c;
    logic [STAGES-1:0][DATA_W-1:0] w_d;
    logic [STAGES-1:0]             w_adv;
    logic                          w_acc;
    logic                          w_emit;
    logic [OCC_W-1:0]              r_occ;

    // Slot i is blocked only when every downstream slot is full and the consumer stalls;
    // this is the adv chain unrolled so it depends on registers and out_ready alone.
    always_comb begin
        logic all_dn;
        w_adv = '0;
        for (int i = 0; i < STAGES; i++) begin
            all_dn = 1'b1;
            for (int j = i + 1; j < STAGES; j++) all_dn = all_dn & w_v[j];
            w_adv[i] = w_v[i] & ~(all_dn & ~bus.out_ready);
        end
    end

    assign bus.in_ready = ~bus.flush & ~rst & (~w_v[0] | w_adv[0]);
    assign w_acc        = bus.in_valid & bus.in_ready;
    assign w_emit       = w_adv[STAGES-1];

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_slot
            logic              w_load;
            logic [CTRL_W-1:0] w_cin;
            logic [DATA_W-1:0] w_din;
            if (g == 0) begin : g_head
                assign w_load = w_acc;
                assign w_cin  = bus.ctrl_in;
                assign w_din  = bus.data_in;
            end else begin : g_body
                assign w_load = w_adv[g-1];
                assign w_cin  = w_c[g-1];
                assign w_din  = w_d[g-1];
            end
            pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slot (
                .clk     (clk),
                .rst     (rst),
                .i_flush (bus.flush),
                .i_load  (w_load),
                .i_adv   (w_adv[g]),
                .i_ctrl  (w_cin),
                .i_data  (w_din),
                .o_v     (w_v[g]),
                .o_c     (w_c[g]),
                .o_d     (w_d[g])
            );
        end
    endgenerate

    // Net change in valid slots is accept minus emit, so the count never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_occ <= '0;
        else if (bus.flush) r_occ <= '0;
        else                r_occ <= r_occ + OCC_W'(w_acc) - OCC_W'(w_emit);
    end

    assign bus.out_valid = w_v[STAGES-1];
    assign bus.ctrl_out  = w_c[STAGES-1];
    assign bus.data_out  = w_d[STAGES-1];
    assign bus.occupancy = r_occ;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: main checks at STAGES=2, async reset at STAGES=1 and 4.
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    logic rst;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.CTRL_W(6), .DATA_W(32), .STAGES(2)) pa ();
    pipe_stage_reg_if #(.CTRL_W(6), .DATA_W(32), .STAGES(1)) pb ();
    pipe_stage_reg_if #(.CTRL_W(6), .DATA_W(32), .STAGES(4)) pc ();

    pipe_stage_reg #(.CTRL_W(6), .DATA_W(32), .STAGES(2)) dut2 (.clk(clk), .rst(rst), .bus(pa));
    pipe_stage_reg #(.CTRL_W(6), .DATA_W(32), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(pb));
    pipe_stage_reg #(.CTRL_W(6), .DATA_W(32), .STAGES(4)) dut4 (.clk(clk), .rst(rst), .bus(pc));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_occ [10];
        exp_occ = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};

        // 1. reset with random inputs
        rst = 1'b1;
        pa.flush = 1'($urandom); pa.in_valid = 1'($urandom); pa.out_ready = 1'($urandom);
        pa.ctrl_in = 6'($urandom); pa.data_in = $urandom;
        pb.flush = 1'b0; pb.in_valid = 1'($urandom); pb.out_ready = 1'($urandom);
        pb.ctrl_in = 6'($urandom); pb.data_in = $urandom;
        pc.flush = 1'b0; pc.in_valid = 1'($urandom); pc.out_ready = 1'($urandom);
        pc.ctrl_in = 6'($urandom); pc.data_in = $urandom;
        tick(); tick();
        chk("rst_out_valid", pa.out_valid, 0);
        chk("rst_ctrl_out",  pa.ctrl_out,  0);
        chk("rst_data_out",  pa.data_out,  0);
        chk("rst_occ",       pa.occupancy, 0);
        chk("rst_in_ready",  pa.in_ready,  0);
        chk("rst_in_ready_s1", pb.in_ready, 0);
        chk("rst_occ_s4",      pc.occupancy, 0);

        pa.flush = 0; pa.in_valid = 0; pa.out_ready = 0; pa.ctrl_in = 0; pa.data_in = 0;
        pb.in_valid = 0; pb.out_ready = 0; pb.ctrl_in = 0; pb.data_in = 0;
        pc.in_valid = 0; pc.out_ready = 0; pc.ctrl_in = 0; pc.data_in = 0;
        #2 rst = 1'b0;
        tick();

        // 2. stream: 8 back-to-back pushes, each visible one edge after acceptance
        pa.out_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            pa.in_valid = (t < 8);
            pa.ctrl_in  = 6'b100001;
            pa.data_in  = 32'hA5A5_0001 + 32'(t);
            #1;
            if (t < 8) chk($sformatf("stream_in_ready_%0d", t), pa.in_ready, 1);
            tick();
            if (t >= 1 && t <= 8) begin
                chk($sformatf("stream_valid_%0d", t), pa.out_valid, 1);
                chk($sformatf("stream_ctrl_%0d", t),  pa.ctrl_out, 6'b100001);
                chk($sformatf("stream_data_%0d", t),  pa.data_out, 32'hA5A5_0001 + 32'(t - 1));
            end else begin
                chk($sformatf("stream_idle_valid_%0d", t), pa.out_valid, 0);
                chk($sformatf("stream_idle_ctrl_%0d", t),  pa.ctrl_out, 0);
            end
            chk($sformatf("stream_occ_%0d", t), pa.occupancy, exp_occ[t]);
        end
        pa.in_valid = 1'b0;

        // 3. backpressure
        pa.out_ready = 1'b0; pa.in_valid = 1'b1; pa.ctrl_in = 6'b000011;
        pa.data_in = 32'd1;
        tick();
        pa.data_in = 32'd2;
        #1 chk("bp_in_ready_2", pa.in_ready, 1);
        tick();
        pa.data_in = 32'd3;
        #1 chk("bp_in_ready_3", pa.in_ready, 0);
        chk("bp_occ_full", pa.occupancy, 2);
        chk("bp_head", pa.data_out, 32'd1);
        tick();
        chk("bp_hold_data", pa.data_out, 32'd1);
        chk("bp_hold_valid", pa.out_valid, 1);
        chk("bp_hold_occ", pa.occupancy, 2);
        pa.out_ready = 1'b1;
        #1 chk("bp_in_ready_release", pa.in_ready, 1);
        tick();
        chk("bp_out2", pa.data_out, 32'd2);
        chk("bp_occ_after2", pa.occupancy, 2);
        pa.in_valid = 1'b0;
        tick();
        chk("bp_out3", pa.data_out, 32'd3);
        chk("bp_occ_after3", pa.occupancy, 1);
        tick();
        chk("bp_drained", pa.out_valid, 0);
        chk("bp_occ_empty", pa.occupancy, 0);

        // 4. bubble collapse with consumer stalled
        pa.out_ready = 1'b0; pa.in_valid = 1'b1; pa.ctrl_in = 6'b001000; pa.data_in = 32'h55;
        tick();
        pa.in_valid = 1'b0;
        chk("bub_not_out", pa.out_valid, 0);
        chk("bub_occ1", pa.occupancy, 1);
        #1 chk("bub_in_ready", pa.in_ready, 1);
        tick();
        chk("bub_moved_valid", pa.out_valid, 1);
        chk("bub_moved_data", pa.data_out, 32'h55);
        chk("bub_moved_occ", pa.occupancy, 1);
        chk("bub_in_ready_after", pa.in_ready, 1);
        pa.out_ready = 1'b1;
        tick();
        chk("bub_drain_occ", pa.occupancy, 0);

        // 5. flush with a full pipe and a pending input
        pa.out_ready = 1'b0; pa.in_valid = 1'b1; pa.ctrl_in = 6'b111111;
        pa.data_in = 32'hF1;
        tick();
        pa.data_in = 32'hF2;
        tick();
        chk("fl_occ_pre", pa.occupancy, 2);
        chk("fl_head_pre", pa.data_out, 32'hF1);
        pa.flush = 1'b1; pa.data_in = 32'hF3;
        #1 chk("fl_in_ready", pa.in_ready, 0);
        tick();
        pa.flush = 1'b0; pa.in_valid = 1'b0;
        chk("fl_valid", pa.out_valid, 0);
        chk("fl_ctrl", pa.ctrl_out, 0);
        chk("fl_occ", pa.occupancy, 0);
        chk("fl_data_hold", pa.data_out, 32'hF1);
        pa.out_ready = 1'b1;
        tick();
        chk("fl_no_accept_valid", pa.out_valid, 0);
        chk("fl_no_accept_occ", pa.occupancy, 0);
        pa.out_ready = 1'b0;

        // 6. async reset mid-cycle on full STAGES=1 and STAGES=4 pipes
        pb.out_ready = 1'b0; pc.out_ready = 1'b0;
        pb.in_valid = 1'b1; pc.in_valid = 1'b1;
        pb.ctrl_in = 6'b010010; pc.ctrl_in = 6'b010010;
        for (int k = 0; k < 4; k++) begin
            pb.data_in = 32'hC0 + 32'(k);
            pc.data_in = 32'hC0 + 32'(k);
            tick();
        end
        chk("s1_full_occ", pb.occupancy, 1);
        chk("s1_full_data", pb.data_out, 32'hC0);
        chk("s4_full_occ", pc.occupancy, 4);
        chk("s4_full_in_ready", pc.in_ready, 0);
        chk("s4_full_data", pc.data_out, 32'hC0);
        #2 rst = 1'b1;
        #1;
        chk("s1_arst_valid", pb.out_valid, 0);
        chk("s1_arst_ctrl", pb.ctrl_out, 0);
        chk("s1_arst_data", pb.data_out, 0);
        chk("s1_arst_occ", pb.occupancy, 0);
        chk("s4_arst_valid", pc.out_valid, 0);
        chk("s4_arst_data", pc.data_out, 0);
        chk("s4_arst_occ", pc.occupancy, 0);
        #1 rst = 1'b0;
        pb.out_ready = 1'b1; pc.out_ready = 1'b1;
        pb.data_in = 32'h77; pc.data_in = 32'h77;
        #1 chk("s1_resume_in_ready", pb.in_ready, 1);
        tick();
        pb.in_valid = 1'b0; pc.in_valid = 1'b0;
        chk("s1_resume_valid", pb.out_valid, 1);
        chk("s1_resume_data", pb.data_out, 32'h77);
        chk("s1_resume_ctrl", pb.ctrl_out, 6'b010010);
        chk("s4_resume_occ", pc.occupancy, 1);
        chk("s4_resume_not_out", pc.out_valid, 0);
        tick();
        chk("s1_resume_drain", pb.out_valid, 0);
        tick();
        chk("s4_resume_not_out2", pc.out_valid, 0);
        tick();
        chk("s4_resume_valid", pc.out_valid, 1);
        chk("s4_resume_data", pc.data_out, 32'h77);
        chk("s4_resume_ctrl", pc.ctrl_out, 6'b010010);
        tick();
        chk("s4_resume_drain", pc.occupancy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
